// File: rtl/tank_ctrl_n.sv
// Tank level controller: debounced thermometer sensor bus feeding an
// EMPTY/HALF/FULL/FAULT FSM with round-robin single-pump duty in HALF.
module tank_ctrl_n #(
  parameter int N_PUMPS  = 2,
  parameter int N_SENS   = 2,
  parameter int DEBOUNCE = 4,
  localparam int PW      = $clog2(N_PUMPS)
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [N_SENS-1:0]   level,
  input  logic [N_PUMPS-1:0]  pump_en,
  input  logic                fault_clr,
  output logic [N_PUMPS-1:0]  pump,
  output logic [1:0]          state,
  output logic                fault,
  output logic [PW-1:0]       ptr
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_HALF  = 2'b01,
    S_FAULT = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t             st_q, st_d, cls;
  logic [N_SENS-1:0]  prev_q, lvl_q, lvl_inc;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d, ptr_adv, cand;
  logic [N_PUMPS-1:0] pump_q, pump_d;
  logic               valid, found;

  // Run length of identical samples, saturating at DEBOUNCE.
  always_comb begin
    if (level != prev_q)
      cnt_d = CW'(1);
    else if (cnt_q == CW'(DEBOUNCE))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      prev_q <= '1;
      cnt_q  <= '0;
      lvl_q  <= '1;
    end else begin
      prev_q <= level;
      cnt_q  <= cnt_d;
      if (cnt_d == CW'(DEBOUNCE))
        lvl_q <= level;
    end
  end

  // Thermometer code 0..01..1 is exactly the set where x & (x+1) == 0.
  assign lvl_inc = lvl_q + N_SENS'(1);
  assign valid   = (lvl_q & lvl_inc) == '0;

  always_comb begin
    if (!valid)
      cls = S_FAULT;
    else if (lvl_q == '1)
      cls = S_FULL;
    else if (lvl_q == '0)
      cls = S_EMPTY;
    else
      cls = S_HALF;
  end

  // First enabled pump after ptr, cyclically; holds when none is enabled.
  always_comb begin
    ptr_adv = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_PUMPS; i++) begin
      cand = PW'((32'(ptr_q) + i) % N_PUMPS);
      if (!found && pump_en[cand]) begin
        ptr_adv = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    st_d   = cls;
    ptr_d  = ptr_q;
    pump_d = '0;
    if (st_q == S_FAULT && !(fault_clr && valid))
      st_d = S_FAULT;
    if (st_q == S_HALF && (st_d != S_HALF || !pump_en[ptr_q]))
      ptr_d = ptr_adv;
    unique case (st_d)
      S_EMPTY: pump_d = pump_en;
      S_HALF:  pump_d = (N_PUMPS'(1) << ptr_q) & pump_en;
      S_FULL:  pump_d = '0;
      S_FAULT: pump_d = '0;
      default: pump_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      st_q   <= S_FULL;
      ptr_q  <= '0;
      pump_q <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      pump_q <= pump_d;
    end
  end

  assign pump  = pump_q;
  assign state = st_q;
  assign fault = (st_q == S_FAULT);
  assign ptr   = ptr_q;

endmodule

// File: tb/tb_tank_ctrl_n.sv
// Self-checking bench for tank_ctrl_n (3 pumps, 3 sensors, debounce 4):
// directed scenarios with literal expectations plus randomized traffic.
module tb_tank_ctrl_n;

  localparam int NP = 3;
  localparam int NS = 3;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] level;
  logic [NP-1:0] pump_en;
  logic          fault_clr;
  logic [NP-1:0] pump;
  logic [1:0]    state;
  logic          fault;
  logic [1:0]    ptr;

  int passed = 0;
  int total  = 0;

  tank_ctrl_n #(.N_PUMPS(NP), .N_SENS(NS), .DEBOUNCE(DB)) dut (
    .clk(clk), .Reset(rst), .level(level), .pump_en(pump_en),
    .fault_clr(fault_clr), .pump(pump), .state(state), .fault(fault), .ptr(ptr)
  );

  always #5 clk = ~clk;

  // Reference model: states coded EMPTY=0 HALF=1 FAULT=2 FULL=3.
  logic [NS-1:0] hist[$];
  logic [NS-1:0] m_lvl;
  int            m_state, m_ptr;
  logic [NP-1:0] m_pump;
  bit            m_ok = 0;

  function automatic int classify(input logic [NS-1:0] v);
    int k;
    logic [NS-1:0] therm;
    k = $countones(v);
    therm = NS'((1 << k) - 1);
    if (v != therm) return 2;
    if (k == NS) return 3;
    if (k == 0) return 0;
    return 1;
  endfunction

  function automatic int next_enabled(input int p, input logic [NP-1:0] en);
    for (int off = 1; off <= NP; off++) begin
      int idx;
      idx = (p + off) % NP;
      if (en[idx]) return idx;
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      m_lvl   = '1;
      m_state = 3;
      m_ptr   = 0;
      m_pump  = '0;
      m_ok    = 1;
    end else if (m_ok) begin
      int c, nst;
      bit same;
      c   = classify(m_lvl);
      nst = (m_state == 2 && !(fault_clr && c != 2)) ? 2 : c;
      case (nst)
        0:       m_pump = pump_en;
        1:       m_pump = pump_en & NP'(1 << m_ptr);
        default: m_pump = '0;
      endcase
      if (m_state == 1 && (nst != 1 || !pump_en[m_ptr]))
        m_ptr = next_enabled(m_ptr, pump_en);
      m_state = nst;
      hist.push_back(level);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        same = 1;
        foreach (hist[i]) if (hist[i] != level) same = 0;
        if (same) m_lvl = level;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_pump",  int'(pump),  int'(m_pump));
      check("model_state", int'(state), m_state);
      check("model_fault", int'(fault), int'(m_state == 2));
      check("model_ptr",   int'(ptr),   m_ptr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string tag, input int st, input int pm, input int pt, input int ft);
    check({tag, "_state"}, int'(state), st);
    check({tag, "_pump"},  int'(pump),  pm);
    if (pt >= 0) check({tag, "_ptr"}, int'(ptr), pt);
    check({tag, "_fault"}, int'(fault), ft);
  endtask

  localparam logic [NS-1:0] LV [0:5] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b101};

  initial begin
    rst = 1; level = 3'b000; pump_en = 3'b111; fault_clr = 0;
    #1;
    // 1: reset, then EMPTY after debounce
    tick(2);
    expect4("rst", 3, 0, 0, 0);
    rst = 0;
    tick(4);
    expect4("db_wait", 3, 0, 0, 0);
    tick(1);
    expect4("empty", 0, 7, 0, 0);
    // 2: rotation through HALF
    level = 3'b001; tick(6); expect4("half0", 1, 1, 0, 0);
    level = 3'b111; tick(6); expect4("full0", 3, 0, 1, 0);
    level = 3'b001; tick(6); expect4("half1", 1, 2, 1, 0);
    level = 3'b111; tick(6); expect4("full1", 3, 0, 2, 0);
    level = 3'b001; tick(6); expect4("half2", 1, 4, 2, 0);
    level = 3'b111; tick(6); expect4("wrap", 3, 0, 0, 0);
    // 3: short glitches ignored
    level = 3'b011; tick(3); level = 3'b111; tick(6); expect4("glitch", 3, 0, 0, 0);
    level = 3'b101; tick(3); level = 3'b111; tick(6); expect4("glitch_inv", 3, 0, 0, 0);
    // 4: fault latch and clear
    level = 3'b101; tick(5); expect4("fault", 2, 0, 0, 1);
    fault_clr = 1; tick(1); fault_clr = 0; expect4("clr_invalid", 2, 0, 0, 1);
    level = 3'b111; tick(6); expect4("sticky", 2, 0, 0, 1);
    fault_clr = 1; tick(1); fault_clr = 0; expect4("clr_ok", 3, 0, 0, 0);
    // 5: pump_en drops the active pump in HALF
    level = 3'b001; tick(6);
    level = 3'b111; tick(6); expect4("pre5", 3, 0, 1, 0);
    level = 3'b001; tick(6); expect4("half_p1", 1, 2, 1, 0);
    pump_en = 3'b101; tick(1); expect4("idle", 1, 0, 2, 0);
    tick(1); expect4("moved", 1, 4, 2, 0);
    pump_en = 3'b000; tick(2); expect4("none_en", 1, 0, 2, 0);
    // 6: reset mid-operation
    pump_en = 3'b111; level = 3'b000; tick(6); expect4("empty2", 0, 7, -1, 0);
    rst = 1; tick(1); rst = 0; expect4("midrst", 3, 0, 0, 0);
    tick(4); expect4("re_wait", 3, 0, 0, 0);
    tick(1); expect4("re_empty", 0, 7, 0, 0);

    // Randomized traffic
    for (int s = 0; s < 350; s++) begin
      int hold;
      if ($urandom_range(0, 9) == 0) level = NS'($urandom_range(0, 7));
      else level = LV[$urandom_range(0, 5)];
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        fault_clr = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) pump_en = NP'($urandom_range(0, 7));
        rst = ($urandom_range(0, 200) == 0);
        tick(1);
      end
    end
    rst = 0; fault_clr = 0;
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
